// File: rtl/rr_credit_arbiter_dataless_pkg.sv
// rr_credit_arbiter_dataless_pkg: shared widths and arbitration state type
package rr_credit_arbiter_dataless_pkg;
  typedef enum logic {ARB_OPEN, ARB_LOCKED} arb_state_e;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic int cnt_w(input int c);
    return $clog2(c + 1);
  endfunction
endpackage

// File: rtl/rr_priority_dataless.sv
// rr_priority_dataless: rotating priority encoder, first set req at or after ptr
module rr_priority_dataless
  import rr_credit_arbiter_dataless_pkg::*;
#(
  parameter int N = 2,
  parameter int W = idx_w(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         any,
  output logic [W-1:0] winner
);
  // Scanning from the far end down lets the nearest requester win last
  always_comb begin
    any = 1'b0;
    winner = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % N]) begin
        any = 1'b1;
        winner = W'((int'(ptr) + k) % N);
      end
    end
  end
endmodule

// File: rtl/rr_credit_arbiter_dataless.sv
// rr_credit_arbiter_dataless: round-robin arbiter with credit-capped dataless handshake
module rr_credit_arbiter_dataless
  import rr_credit_arbiter_dataless_pkg::*;
#(
  parameter int NUM_INPUTS = 2,
  parameter int NUM_CREDITS = 2,
  localparam int IDX_W = idx_w(NUM_INPUTS),
  localparam int CNT_W = cnt_w(NUM_CREDITS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_INPUTS-1:0] ins_valid,
  output logic [NUM_INPUTS-1:0] ins_ready,
  output logic                  outs_valid,
  input  logic                  outs_ready,
  output logic [IDX_W-1:0]      outs_index,
  input  logic                  credit_return,
  output logic                  idle,
  output logic                  credit_err
);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(NUM_CREDITS);
  arb_state_e       state;
  logic [IDX_W-1:0] ptr, lock_idx, winner, ptr_nxt;
  logic [CNT_W-1:0] cnt;
  logic             any, xfer;
  rr_priority_dataless #(.N(NUM_INPUTS), .W(IDX_W)) u_prio (
    .req(ins_valid),
    .ptr(ptr),
    .any(any),
    .winner(winner)
  );
  // Gating with rst drops valid/ready the moment reset asserts, not at the next edge
  assign outs_valid = rst & ((state == ARB_LOCKED) | (any & (cnt != '0)));
  assign outs_index = (state == ARB_LOCKED) ? lock_idx : winner;
  assign xfer = outs_valid & outs_ready;
  assign ins_ready = xfer ? (NUM_INPUTS'(1) << outs_index) : '0;
  assign ptr_nxt = (outs_index == IDX_W'(NUM_INPUTS - 1)) ? '0 : outs_index + IDX_W'(1);
  assign idle = (cnt == FULL);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ARB_OPEN;
      ptr <= '0;
      lock_idx <= '0;
      cnt <= FULL;
      credit_err <= 1'b0;
    end else begin
      if (xfer) begin
        state <= ARB_OPEN;
        ptr <= ptr_nxt;
      end else if (state == ARB_OPEN && outs_valid) begin
        state <= ARB_LOCKED;
        lock_idx <= winner;
      end
      if (xfer && !credit_return) cnt <= cnt - CNT_W'(1);
      else if (!xfer && credit_return && cnt != FULL) cnt <= cnt + CNT_W'(1);
      if (!xfer && credit_return && cnt == FULL) credit_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_rr_credit_arbiter_dataless.sv
// tb_rr_credit_arbiter_dataless: directed and random checks against a behavioural model
module tb_rr_credit_arbiter_dataless;
  localparam int N = 3;
  localparam int C = 2;
  logic clk = 1'b0;
  logic rst;
  logic [N-1:0] ins_valid, ins_ready;
  logic outs_valid, outs_ready, credit_return, idle, credit_err;
  logic [1:0] outs_index;
  int n_checks = 0;
  int n_fail = 0;
  int m_ptr, m_lock_idx, m_cnt;
  bit m_locked, m_err;
  always #5 clk = ~clk;
  rr_credit_arbiter_dataless #(.NUM_INPUTS(N), .NUM_CREDITS(C)) dut (
    .clk(clk),
    .rst(rst),
    .ins_valid(ins_valid),
    .ins_ready(ins_ready),
    .outs_valid(outs_valid),
    .outs_ready(outs_ready),
    .outs_index(outs_index),
    .credit_return(credit_return),
    .idle(idle),
    .credit_err(credit_err)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic int pick();
    for (int k = 0; k < N; k++)
      if (ins_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction
  function automatic bit m_valid();
    return m_locked || (pick() >= 0 && m_cnt > 0);
  endfunction
  function automatic int m_index();
    return m_locked ? m_lock_idx : pick();
  endfunction
  task automatic model_reset();
    m_ptr = 0;
    m_lock_idx = 0;
    m_cnt = C;
    m_locked = 0;
    m_err = 0;
  endtask
  task automatic drive(input logic [N-1:0] v, input logic r, input logic cr);
    ins_valid = v;
    outs_ready = r;
    credit_return = cr;
    #1;
    check("valid", outs_valid, m_valid());
    if (m_valid()) check("index", outs_index, m_index());
    check("ready", ins_ready, (m_valid() && r) ? (1 << m_index()) : 0);
    check("idle", idle, m_cnt == C);
    check("err", credit_err, m_err);
  endtask
  task automatic tick();
    bit v, x;
    int idx;
    v = m_valid();
    idx = m_index();
    x = v && outs_ready;
    @(posedge clk);
    if (x) begin
      m_ptr = (idx + 1) % N;
      m_locked = 0;
    end else if (v) begin
      m_locked = 1;
      m_lock_idx = idx;
    end
    if (x && !credit_return) m_cnt--;
    else if (!x && credit_return) begin
      if (m_cnt == C) m_err = 1;
      else m_cnt++;
    end
    @(negedge clk);
  endtask
  task automatic do_reset();
    rst = 1'b0;
    #1;
    check("rst_valid", outs_valid, 0);
    check("rst_ready", ins_ready, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask
  initial begin
    rst = 1'b0;
    ins_valid = '0;
    outs_ready = 1'b0;
    credit_return = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    drive(3'b000, 0, 0);
    check("reset_idle", idle, 1);
    check("reset_err", credit_err, 0);
    tick();
    // round-robin rotation with one credit back each cycle
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(3'b111, 1, 1);
      check("alt_idx", outs_index, i % 3);
      tick();
    end
    drive(3'b000, 0, 0);
    check("alt_idle", idle, 1);
    tick();
    // credit exhaustion and recovery
    do_reset();
    drive(3'b111, 1, 0); tick();
    drive(3'b111, 1, 0); tick();
    drive(3'b111, 1, 0);
    check("exh_valid", outs_valid, 0);
    check("exh_idle", idle, 0);
    tick();
    drive(3'b111, 1, 1);
    check("ret_same_cycle", outs_valid, 0);
    tick();
    drive(3'b111, 1, 0);
    check("ret_next_cycle", outs_valid, 1);
    tick();
    // lock stability
    do_reset();
    drive(3'b010, 0, 0); tick();
    drive(3'b011, 0, 0);
    check("lock_idx", outs_index, 1);
    tick();
    drive(3'b011, 0, 0); tick();
    drive(3'b011, 1, 0);
    check("lock_ready", ins_ready, 3'b010);
    tick();
    drive(3'b111, 1, 0);
    check("ptr_after_lock", outs_index, 2);
    tick();
    // simultaneous transfer/return and overflow
    do_reset();
    drive(3'b001, 1, 0); tick();
    drive(3'b001, 1, 1); tick();
    drive(3'b000, 0, 0);
    check("simul_idle", idle, 0);
    tick();
    drive(3'b000, 0, 1); tick();
    drive(3'b000, 0, 1);
    check("pre_ovf_err", credit_err, 0);
    tick();
    drive(3'b000, 0, 0);
    check("ovf_err", credit_err, 1);
    check("ovf_idle", idle, 1);
    tick();
    drive(3'b000, 0, 0);
    check("ovf_sticky", credit_err, 1);
    tick();
    // asynchronous reset while locked
    do_reset();
    drive(3'b111, 1, 0); tick();
    drive(3'b111, 0, 0); tick();
    drive(3'b000, 1, 0);
    check("locked_valid", outs_valid, 1);
    check("locked_idx", outs_index, 1);
    do_reset();
    drive(3'b000, 0, 0);
    check("post_rst_idle", idle, 1);
    check("post_rst_err", credit_err, 0);
    drive(3'b111, 1, 0);
    check("post_rst_ptr", outs_index, 0);
    tick();
    // random traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      drive(N'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 9) < 4);
      tick();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
